// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - Montgomery modular exponentiation sequencer (square-and-always-multiply)
module mont_exp_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int EXP_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] m,
    input  logic [WORD_WIDTH-1:0] base_mont,
    input  logic [WORD_WIDTH-1:0] one_mont,
    input  logic [EXP_WIDTH-1:0]  exponent,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  mm_enable,
    output logic [WORD_WIDTH-1:0] mm_x,
    output logic [WORD_WIDTH-1:0] mm_y,
    output logic [WORD_WIDTH-1:0] mm_m,
    output logic [WORD_WIDTH:0]   mm_R,
    input  logic                  mm_done,
    input  logic [WORD_WIDTH-1:0] mm_result
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_CONV_ISSUE,
        S_CONV_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WORD_WIDTH-1:0] r_m;
    logic [WORD_WIDTH-1:0] r_base;
    logic [EXP_WIDTH-1:0]  r_exp;
    logic [WORD_WIDTH-1:0] r_acc;
    logic [IDX_W-1:0]      r_idx;
    logic [WORD_WIDTH-1:0] r_result;
    logic                  r_err;

    assign mm_R   = {1'b1, {WORD_WIDTH{1'b0}}};
    assign mm_m   = r_m;
    assign result = r_result;
    assign err    = r_err;

    // State register; reset aborts any multiplier operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and decoded outputs; operands are held steady across each issue/wait pair
    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        mm_enable = 1'b0;
        mm_x      = r_acc;
        mm_y      = r_acc;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = m[0] ? S_SQ_ISSUE : S_DONE;
                end
            end
            S_SQ_ISSUE: begin
                mm_enable = 1'b1;
                w_next    = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                if (mm_done) begin
                    w_next = S_MUL_ISSUE;
                end
            end
            S_MUL_ISSUE: begin
                mm_enable = 1'b1;
                mm_y      = r_base;
                w_next    = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                mm_y = r_base;
                if (mm_done) begin
                    w_next = (r_idx == '0) ? S_CONV_ISSUE : S_SQ_ISSUE;
                end
            end
            S_CONV_ISSUE: begin
                mm_enable = 1'b1;
                mm_y      = WORD_WIDTH'(1);
                w_next    = S_CONV_WAIT;
            end
            S_CONV_WAIT: begin
                mm_y = WORD_WIDTH'(1);
                if (mm_done) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, accumulator updates (multiply product kept only for set exponent bits), result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m      <= '0;
            r_base   <= '0;
            r_exp    <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (m[0]) begin
                            r_m    <= m;
                            r_base <= base_mont;
                            r_exp  <= exponent;
                            r_acc  <= one_mont;
                            r_idx  <= IDX_W'(EXP_WIDTH - 1);
                            r_err  <= 1'b0;
                        end else begin
                            r_err    <= 1'b1;
                            r_result <= '0;
                        end
                    end
                end
                S_SQ_WAIT: begin
                    if (mm_done) begin
                        r_acc <= mm_result;
                    end
                end
                S_MUL_WAIT: begin
                    if (mm_done) begin
                        if (r_exp[r_idx]) begin
                            r_acc <= mm_result;
                        end
                        if (r_idx != '0) begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end
                end
                S_CONV_WAIT: begin
                    if (mm_done) begin
                        r_result <= mm_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, the modulus/operand width shared with the attached Montgomery multiplier.
REQ-002 SHALL have parameter EXP_WIDTH, default 32, the exponent width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin one exponentiation.
REQ-006 SHALL have port m, input, WORD_WIDTH, the modulus.
REQ-007 SHALL have port base_mont, input, WORD_WIDTH, the base in Montgomery form (x*R mod m).
REQ-008 SHALL have port one_mont, input, WORD_WIDTH, the value R mod m.
REQ-009 SHALL have port exponent, input, EXP_WIDTH, the exponent.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1, set when the completed request had an even m.
REQ-013 SHALL have port result, output, WORD_WIDTH, holding base^exponent mod m in normal (non-Montgomery) form.
REQ-014 SHALL have port mm_enable, output, 1, one-cycle start pulse to the multiplier.
REQ-015 SHALL have ports mm_x and mm_y, output, WORD_WIDTH each, the multiplier operands.
REQ-016 SHALL have port mm_m, output, WORD_WIDTH, the modulus to the multiplier.
REQ-017 SHALL have port mm_R, output, WORD_WIDTH+1, driven constantly to 2^WORD_WIDTH.
REQ-018 SHALL have port mm_done, input, 1, the multiplier completion pulse.
REQ-019 SHALL have port mm_result, input, WORD_WIDTH, the multiplier product, valid in the cycle mm_done is high.

Function
REQ-020 SHALL implement the states IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, CONV_ISSUE, CONV_WAIT and DONE.
REQ-021 In IDLE with start=1 and m[0]=1, SHALL register m, base_mont and exponent, set acc=one_mont and idx=EXP_WIDTH-1, clear err, and go to SQ_ISSUE.
REQ-022 In IDLE with start=1 and m[0]=0, SHALL go to DONE with err=1 and result=0, issuing no multiplier operation.
REQ-023 In SQ_ISSUE SHALL drive mm_x=mm_y=acc and mm_enable=1 for exactly one cycle, then go to SQ_WAIT.
REQ-024 In SQ_WAIT SHALL wait indefinitely for mm_done, capture acc=mm_result in that cycle, and go to MUL_ISSUE.
REQ-025 In MUL_ISSUE SHALL drive mm_x=acc, mm_y=base_mont (registered) and pulse mm_enable, then go to MUL_WAIT.
REQ-026 In MUL_WAIT on mm_done SHALL load acc=mm_result only if exponent[idx]=1 and otherwise discard the product; this dummy multiply keeps operation count independent of exponent value.
REQ-027 After MUL_WAIT completes SHALL go to CONV_ISSUE when idx=0, otherwise decrement idx and go to SQ_ISSUE.
REQ-028 In CONV_ISSUE SHALL drive mm_x=acc, mm_y=1 and pulse mm_enable; in CONV_WAIT on mm_done SHALL load result=mm_result and go to DONE.
REQ-029 In DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-030 Every request SHALL issue exactly 2*EXP_WIDTH+1 multiplier operations, with no two mm_enable pulses less than one mm_done apart.
REQ-031 mm_x, mm_y and mm_m SHALL remain stable from each mm_enable pulse through the matching mm_done.
REQ-032 result and err SHALL hold their values from DONE until the next accepted start.
REQ-033 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-034 mm_done asserted outside the *_WAIT states SHALL be ignored.

Reset
REQ-035 reset_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, err=0, mm_enable=0, result=0, acc=0 and idx=0, aborting any operation in progress.
REQ-036 After reset release SHALL accept a new start on the first clock edge and SHALL ignore any in-flight mm_done from an aborted operation.

Verification (WORD_WIDTH=8, EXP_WIDTH=8, R=256, bench drives a behavioural multiplier with a 5-cycle done)
REQ-037 m=13, base_mont=5 (x=2), one_mont=9, exponent=5 -> result=6, done pulse once, exactly 17 mm_enable pulses.
REQ-038 m=13, base_mont=5, one_mont=9, exponent=0 -> result=1; exponent=1 -> result=2; exponent=12 -> result=1.
REQ-039 m=12 with start -> done after 1 cycle in DONE, err=1, result=0, zero mm_enable pulses.
REQ-040 start re-asserted during SQ_WAIT -> ignored; the single result is 6 for the REQ-037 operands.
REQ-041 reset_n pulsed low during the 4th MUL_WAIT, then a fresh start with the REQ-037 operands -> busy=0 and done=0 immediately on reset, then result=6.
REQ-042 Random odd m in [3,255], random x and exponent, with base_mont and one_mont computed by the bench -> result equals the bench modular-power model across at least 1000 runs.
